// File: rtl/nibble_serial_addsub.sv
// Serial WIDTH-bit adder/subtractor: one 4-bit slice processes one nibble per clock,
// LSB first, with the carry held in a register between nibbles.
module nibble_serial_addsub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = $clog2(NIB);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_r, b_r;
  logic             ctrl_r, carry_r;
  logic [CW-1:0]    cnt;
  logic [3:0]       a_nib, b_nib;
  logic [4:0]       slice;
  logic             last;

  // Select the current nibble; b is inverted here so subtract is a + ~b + carry_r.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned k = 0; k < NIB; k++) begin
      if (cnt == CW'(k)) begin
        a_nib = a_r[4*k +: 4];
        b_nib = b_r[4*k +: 4] ^ {4{ctrl_r}};
      end
    end
  end

  assign slice = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_r};
  assign last  = (cnt == CW'(NIB - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r      <= '0;
      b_r      <= '0;
      ctrl_r   <= 1'b0;
      carry_r  <= 1'b0;
      cnt      <= '0;
      s        <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            ctrl_r  <= ctrl;
            carry_r <= ctrl;
            cnt     <= '0;
          end
        end
        RUN: begin
          for (int unsigned k = 0; k < NIB; k++) begin
            if (cnt == CW'(k)) s[4*k +: 4] <= slice[3:0];
          end
          carry_r <= slice[4];
          cnt     <= cnt + CW'(1);
          if (last) begin
            cout     <= slice[4];
            overflow <= (a_r[WIDTH-1] == (b_r[WIDTH-1] ^ ctrl_r)) &&
                        (slice[3] != a_r[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
- Multi-cycle WIDTH-bit adder/subtractor that processes operands one nibble (4 bits) per clock, LSB nibble first.
- Uses a single 4-bit ripple add/sub slice plus a registered carry.
- Sits directly upstream of the result consumer. Operands arrive through a start/busy/done handshake, and the full-width sum plus flags is presented when done pulses.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 8.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE
- ctrl  input  1  0 = add (a+b), 1 = subtract (a−b); sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while nibbles are being processed
- done  output  1  one-cycle pulse when the result is valid
- s  output  WIDTH  result, held until the next accepted start
- cout  output  1  final carry out; on subtract, 1 = no borrow (a ≥ b unsigned)
- overflow  output  1  signed (two's complement) overflow of the full-width operation

Behaviour:
- Reset:
  - When rst_n=0 at a rising edge: state=IDLE; busy=0, done=0, s=0, cout=0, overflow=0; operand registers, carry and nibble counter cleared.
  - Reset has priority over everything, including mid-operation; an operation in progress is abandoned with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge: latch a, b, ctrl; carry_reg ← ctrl; counter ← 0; next state RUN.
  - s, cout and overflow keep their previous values until the first RUN edge.
- RUN (busy=1):
  - Each edge processes nibble k=counter: {c,n} = a[4k+3:4k] + (b[4k+3:4k] XOR {4{ctrl}}) + carry_reg.
  - Write n into s[4k+3:4k]; carry_reg ← c; counter ← counter+1.
  - Only the nibble being processed changes; previously written nibbles are kept.
  - On the edge processing the last nibble (k = WIDTH/4−1):
    - cout ← c.
    - overflow ← (a_msb == b'_msb) && (sum_msb != a_msb), where b' = b XOR {WIDTH{ctrl}}.
    - Next state DONE.
- DONE:
  - done=1, busy=0 for exactly one cycle, then IDLE.
  - start in DONE is ignored; back-to-back requests must wait for IDLE.
- Timing:
  - start is accepted at edge t.
  - busy is high in cycles t+1 … t+WIDTH/4.
  - done is high in cycle t+WIDTH/4+1.
  - Latency = WIDTH/4+1 cycles; for WIDTH=16, done is 5 cycles after start is accepted.
- Input stability:
  - start, ctrl, a and b are ignored while busy=1 or done=1.
  - Input changes after acceptance do not affect the result.
- Arithmetic:
  - Modulo 2^WIDTH.
  - Subtract is computed as a + ~b + 1; the +1 comes from carry_reg initialised to ctrl.
  - The carry propagates between nibbles only through carry_reg; there is no combinational path across nibbles.
- Output stability: s, cout and overflow remain stable from done until the first RUN edge of the next operation.

Test Plan:
- Add with nibble carry chain: ctrl=0, a=16'h000F, b=16'h0001 → after 5 cycles done=1, s=16'h0010, cout=0, overflow=0; busy high for exactly 4 cycles.
- Subtract, no borrow and with borrow:
  - ctrl=1, a=5, b=3 → s=16'h0002, cout=1, overflow=0.
  - ctrl=1, a=3, b=5 → s=16'hFFFE, cout=0, overflow=0.
- Flags:
  - ctrl=0, a=16'h7FFF, b=16'h0001 → s=16'h8000, overflow=1, cout=0.
  - ctrl=0, a=16'hFFFF, b=16'h0001 → s=16'h0000, cout=1, overflow=0.
  - ctrl=1, a=16'h8000, b=16'h0001 → s=16'h7FFF, overflow=1, cout=1.
- Mixed add: ctrl=0, a=16'h1234, b=16'h0FFF → s=16'h2233, cout=0.
  - Then change a, b and ctrl while busy and pulse start → result unchanged; no second operation begins.
  - done is a single-cycle pulse.
- Reset mid-operation: start an add, drive rst_n=0 on the 2nd RUN cycle → next cycle busy=0, done=0, s=0, cout=0, overflow=0, state IDLE. No done pulse follows.
  - A new start then completes normally with the correct sum.
